piso_tx: RTL
============

# piso_tx

Parallel-in, serial-out transmitter: accepts a WIDTH-bit word over a valid/ready load handshake and drives it onto a single serial line, one bit per clock, with a frame qualifier. It is the transmit end feeding our serial-in shift-register chain (`serial_in`), replacing hand-driven bit stimulus. It supports back-to-back words with no idle gap.

## Interface
Parameters:
- WIDTH, 4: data word width in bits; legal values are ≥ 2.
- MSB_FIRST, 0: 0 sends bit 0 first; 1 sends bit WIDTH-1 first.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- data_in  in  WIDTH  word to transmit; sampled only on an accepted handshake.
- load_valid  in  1  producer has a word on data_in.
- load_ready  out  1  transmitter can accept a word this cycle.
- serial_out  out  1  serial data, registered.
- frame  out  1  high while serial_out carries a valid bit, registered.
- done  out  1  high during the final bit of a frame, registered.

## Operation
- States: IDLE and SHIFT.
- Reset values: state IDLE; shift_reg 0; bit counter 0; serial_out 0; frame 0; done 0.
- load_ready:
  - 0 while rst is high.
  - Otherwise 1 in IDLE, and 1 in SHIFT during the last bit of a frame.
  - 0 in SHIFT for all other bits.
- Accept occurs on a clock edge with load_valid & load_ready. On accept:
  - Capture data_in.
  - Drive the first bit onto serial_out and set frame=1.
  - Set the counter to 0 and enter (or stay in) SHIFT.
- SHIFT: each edge advances one bit toward the output end and increments the counter. Frame length N = WIDTH (WIDTH+1 with parity, see Configuration).
- Last bit (counter == N-1):
  - done=1 coincident with that bit.
  - If an accept occurs on the closing edge, the next word's first bit follows immediately: frame stays 1, no gap.
  - Otherwise the closing edge returns to IDLE with serial_out=0, frame=0, done=0.
- load_valid in SHIFT with load_ready=0 is ignored. The producer must hold the word until accepted.
- data_in changes outside the accept edge have no effect.
- Reset mid-frame: all outputs go to 0 immediately (asynchronously). The partial word is discarded, with no resume.

## Timing
- Latency: the bit appears on serial_out in the cycle following the accept edge, i.e. 1 clock from accept to first bit.
- A frame occupies exactly N consecutive cycles of frame=1.
- done is high for exactly 1 cycle per word, aligned with the last bit.
- Sustained throughput is one word per N cycles when load_valid is held high.
- Counter width is $clog2(N) bits. It never exceeds N-1 and wraps to 0 only via accept.

## Configuration
- Macro: PISO_TX_PARITY_EN.
- Defined: one even-parity bit (XOR of all WIDTH data bits) is appended after the data bit, so N = WIDTH+1. done and the load_ready window move to the parity bit.
- Undefined: N = WIDTH, and no parity logic is generated.

## Structure
- Package piso_tx_pkg holds:
  - The state enum typedef (IDLE, SHIFT).
  - The frame-length function computing N from WIDTH and the macro.
- One sub-module, piso_bit_cnt, is natural: a load/increment counter with a terminal-count flag, parameterised by N.
- Shift register, handshake and output registers live in piso_tx.

## Test plan
- WIDTH=4, MSB_FIRST=0, accept 4'b1011 -> serial_out 1,1,0,1 on the 4 cycles after accept; frame high for exactly those 4 cycles; done only on the 4th; then IDLE with serial_out=0.
- Back-to-back: load_valid held high with 4'b1011 then 4'b0110 -> 8 contiguous bits 1,1,0,1,0,1,1,0; frame never drops; done pulses on bits 4 and 8.
- MSB_FIRST=1, accept 4'b1011 -> 1,0,1,1.
- Assert rst after 2 bits of 4'b1011 -> serial_out/frame/done go to 0 at once. After release, accepting 4'b0001 yields 1,0,0,0 with no residue.
- PISO_TX_PARITY_EN defined, accept 4'b1011 -> 1,1,0,1,1 (5-bit frame); done on the parity bit. 4'b0011 -> 1,1,0,0,0.
- load_valid low for 20 cycles after reset -> load_ready=1, frame=0, serial_out=0 throughout. In mid-frame, load_valid high with load_ready=0 -> word not taken and not corrupted.

Source files
------------

// File: rtl/piso_tx_pkg.sv
// Shared types and frame-length helper for the piso_tx serial transmitter.
// Frame length depends on PISO_TX_PARITY_EN (one appended even-parity bit when defined).
package piso_tx_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } piso_state_t;

    function automatic int frame_len(input int width);
`ifdef PISO_TX_PARITY_EN
        return width + 1;
`else
        return width;
`endif
    endfunction

endpackage

// File: rtl/piso_tx_if.sv
// Load handshake and serial output bundle between a word producer and piso_tx.
interface piso_tx_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] data_in;
    logic             load_valid;
    logic             load_ready;
    logic             serial_out;
    logic             frame;
    logic             done;

    modport master (
        output data_in, load_valid,
        input  load_ready, serial_out, frame, done
    );

    modport slave (
        input  data_in, load_valid,
        output load_ready, serial_out, frame, done
    );
endinterface

// File: rtl/piso_bit_cnt.sv
// Bit position counter for piso_tx: cleared on load, stepped on inc, and flags
// both the final position (tc) and the one before it (pre_tc).
module piso_bit_cnt #(
    parameter int N = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic inc,
    output logic tc,
    output logic pre_tc
);
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    logic [CW-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= '0;
        end else if (inc) begin
            count <= count + CW'(1);
        end
    end

    assign tc     = (count == CW'(N - 1));
    assign pre_tc = (count == CW'(N - 2));

endmodule

// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter with valid/ready load and frame/done qualifiers.
// Define PISO_TX_PARITY_EN to append an even-parity bit to every frame.
module piso_tx
    import piso_tx_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int MSB_FIRST = 0
) (
    input  logic     clk,
    input  logic     rst,
    piso_tx_if.slave bus
);
    localparam int N = frame_len(WIDTH);

    piso_state_t   state;
    logic [N-1:0]  shift_reg;
    logic [N-1:0]  send_vec;
    logic          accept;
    logic          tc;
    logic          pre_tc;
    logic          cnt_inc;

    // Reorder the incoming word so bit 0 of send_vec is always transmitted first.
    always_comb begin
        send_vec = '0;
        for (int i = 0; i < WIDTH; i++) begin
            send_vec[i] = (MSB_FIRST != 0) ? bus.data_in[WIDTH-1-i] : bus.data_in[i];
        end
`ifdef PISO_TX_PARITY_EN
        send_vec[WIDTH] = ^bus.data_in;
`endif
    end

    assign bus.load_ready = !rst && ((state == IDLE) || tc);
    assign accept         = bus.load_valid && bus.load_ready;
    assign cnt_inc        = (state == SHIFT) && !tc && !accept;

    piso_bit_cnt #(
        .N(N)
    ) u_bit_cnt (
        .clk    (clk),
        .rst    (rst),
        .load   (accept),
        .inc    (cnt_inc),
        .tc     (tc),
        .pre_tc (pre_tc)
    );

    // An accept on the closing edge of a frame chains straight into the next word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            shift_reg      <= '0;
            bus.serial_out <= 1'b0;
            bus.frame      <= 1'b0;
            bus.done       <= 1'b0;
        end else if (accept) begin
            state          <= SHIFT;
            shift_reg      <= send_vec >> 1;
            bus.serial_out <= send_vec[0];
            bus.frame      <= 1'b1;
            bus.done       <= 1'b0;
        end else if (state == SHIFT) begin
            if (tc) begin
                state          <= IDLE;
                shift_reg      <= '0;
                bus.serial_out <= 1'b0;
                bus.frame      <= 1'b0;
                bus.done       <= 1'b0;
            end else begin
                shift_reg      <= shift_reg >> 1;
                bus.serial_out <= shift_reg[0];
                bus.done       <= pre_tc;
            end
        end
    end

endmodule
